// File: rtl/alu_mem_master.sv
// alu_mem_master: bus master that sequences one ALU register-slave operation
// per accepted command. It writes A, B and OP, sets EX, waits a fixed number
// of cycles, captures the ALU result, clears EX and presents a response.
// All outputs are registered and decoded from the next state, so each output
// changes on the same edge as the state it belongs to.

module alu_mem_master #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RES_WIDTH  = 16,
   parameter int EXEC_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   input  logic [2:0]            cmd_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [RES_WIDTH-1:0]  rsp_result,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wr_data,
   output logic                  bus_rd_wr,
   output logic                  bus_enable,
   input  logic [RES_WIDTH-1:0]  alu_res,
   output logic [15:0]           cmd_count
);

   localparam logic [3:0] S_INIT    = 4'd0;
   localparam logic [3:0] S_IDLE    = 4'd1;
   localparam logic [3:0] S_WR_A    = 4'd2;
   localparam logic [3:0] S_WR_B    = 4'd3;
   localparam logic [3:0] S_WR_OP   = 4'd4;
   localparam logic [3:0] S_WR_EX   = 4'd5;
   localparam logic [3:0] S_WAIT    = 4'd6;
   localparam logic [3:0] S_CAPTURE = 4'd7;
   localparam logic [3:0] S_CLR_EX  = 4'd8;
   localparam logic [3:0] S_RESP    = 4'd9;

   localparam logic [3:0] LAT_VAL = 4'(EXEC_LAT);

   localparam logic [ADDR_WIDTH-1:0] ADDR_A  = ADDR_WIDTH'(2'd0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_B  = ADDR_WIDTH'(2'd1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP = ADDR_WIDTH'(2'd2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_EX = ADDR_WIDTH'(2'd3);

   // Error rule: unknown opcode, or divide with a zero divisor.
   function automatic logic calc_err(input logic [2:0] op, input logic [DATA_WIDTH-1:0] b);
      return (op > 3'd4) || ((op == 3'd4) && (b == {DATA_WIDTH{1'b0}}));
   endfunction

   logic [3:0]            state_r;
   logic [3:0]            state_nxt_s;
   logic                  init_pend_r;
   logic [3:0]            cnt_r;
   logic [3:0]            cnt_nxt_s;
   logic [DATA_WIDTH-1:0] a_r;
   logic [DATA_WIDTH-1:0] b_r;
   logic [2:0]            op_r;
   logic [15:0]           count_r;
   logic [RES_WIDTH-1:0]  rsp_result_r;
   logic                  rsp_err_r;
   logic                  cmd_ready_r;
   logic                  rsp_valid_r;
   logic [ADDR_WIDTH-1:0] bus_addr_r;
   logic [DATA_WIDTH-1:0] bus_wr_data_r;
   logic                  bus_rd_wr_r;
   logic                  bus_enable_r;

   logic                  accept_s;
   logic                  handshake_s;
   logic                  ready_nxt_s;
   logic                  valid_nxt_s;
   logic                  en_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_nxt_s;
   logic [DATA_WIDTH-1:0] data_nxt_s;

   assign accept_s    = (state_r == S_IDLE) && cmd_valid;
   assign handshake_s = (state_r == S_RESP) && rsp_ready;

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         S_INIT: begin
            // The INIT write is shown for one cycle after reset release.
            if (init_pend_r) begin
               state_nxt_s = S_INIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_IDLE: begin
            if (cmd_valid) begin
               state_nxt_s = S_WR_A;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WR_A:  state_nxt_s = S_WR_B;
         S_WR_B:  state_nxt_s = S_WR_OP;
         S_WR_OP: state_nxt_s = S_WR_EX;
         S_WR_EX: begin
            state_nxt_s = S_WAIT;
            cnt_nxt_s   = LAT_VAL;
         end
         S_WAIT: begin
            // Leave on the last wait cycle; <= also guards a zero count.
            if (cnt_r <= 4'd1) begin
               state_nxt_s = S_CAPTURE;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         S_CAPTURE: state_nxt_s = S_CLR_EX;
         S_CLR_EX:  state_nxt_s = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_RESP;
            end
         end
         default: state_nxt_s = S_INIT;
      endcase
   end

   // Output values belonging to the state that will be entered next.
   always_comb begin
      en_nxt_s    = 1'b0;
      addr_nxt_s  = {ADDR_WIDTH{1'b0}};
      data_nxt_s  = {DATA_WIDTH{1'b0}};
      ready_nxt_s = (state_nxt_s == S_IDLE);
      valid_nxt_s = (state_nxt_s == S_RESP);
      case (state_nxt_s)
         S_INIT, S_CLR_EX: begin
            en_nxt_s   = 1'b1;
            addr_nxt_s = ADDR_EX;
         end
         S_WR_A: begin
            // Only reachable on acceptance, so the live operand is the latched one.
            en_nxt_s   = 1'b1;
            addr_nxt_s = ADDR_A;
            data_nxt_s = cmd_a;
         end
         S_WR_B: begin
            en_nxt_s   = 1'b1;
            addr_nxt_s = ADDR_B;
            data_nxt_s = b_r;
         end
         S_WR_OP: begin
            en_nxt_s   = 1'b1;
            addr_nxt_s = ADDR_OP;
            data_nxt_s = DATA_WIDTH'(op_r);
         end
         S_WR_EX: begin
            en_nxt_s   = 1'b1;
            addr_nxt_s = ADDR_EX;
            data_nxt_s = DATA_WIDTH'(1'b1);
         end
         default: begin
            en_nxt_s   = 1'b0;
         end
      endcase
   end

   // State, operand latches, wait counter, result capture and completion count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= S_INIT;
         init_pend_r  <= 1'b1;
         cnt_r        <= 4'd0;
         a_r          <= {DATA_WIDTH{1'b0}};
         b_r          <= {DATA_WIDTH{1'b0}};
         op_r         <= 3'd0;
         count_r      <= 16'd0;
         rsp_result_r <= {RES_WIDTH{1'b0}};
         rsp_err_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         init_pend_r <= 1'b0;
         cnt_r       <= cnt_nxt_s;
         if (accept_s) begin
            a_r  <= cmd_a;
            b_r  <= cmd_b;
            op_r <= cmd_op;
         end
         if (state_r == S_CAPTURE) begin
            rsp_result_r <= alu_res;
            rsp_err_r    <= calc_err(op_r, b_r);
         end
         if (handshake_s) begin
            count_r <= count_r + 16'd1;
         end
      end
   end

   // Registered handshake and bus outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready_r   <= 1'b0;
         rsp_valid_r   <= 1'b0;
         bus_addr_r    <= {ADDR_WIDTH{1'b0}};
         bus_wr_data_r <= {DATA_WIDTH{1'b0}};
         bus_rd_wr_r   <= 1'b0;
         bus_enable_r  <= 1'b0;
      end else begin
         cmd_ready_r   <= ready_nxt_s;
         rsp_valid_r   <= valid_nxt_s;
         bus_addr_r    <= addr_nxt_s;
         bus_wr_data_r <= data_nxt_s;
         bus_rd_wr_r   <= 1'b0;
         bus_enable_r  <= en_nxt_s;
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_result  = rsp_result_r;
   assign rsp_err     = rsp_err_r;
   assign bus_addr    = bus_addr_r;
   assign bus_wr_data = bus_wr_data_r;
   assign bus_rd_wr   = bus_rd_wr_r;
   assign bus_enable  = bus_enable_r;
   assign cmd_count   = count_r;

endmodule
